// File: rtl/imm_pkg.sv
// Shared constants for immediate extraction: format codes, RV32I opcodes, shift funct3.
// Latency: n/a (package only).
// Backpressure: n/a.
package imm_pkg;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_SH   = 3'd6;
    localparam logic [2:0] FMT_Z    = 3'd7;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;
    localparam logic [2:0] F3_PRIV = 3'b000;

endpackage

// File: rtl/imm_decode.sv
// Decodes the immediate format from the opcode and extends the immediate to XLEN.
// Latency: combinational.
// Backpressure: none.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign funct3 = instr[14:12];

    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_JALR: fmt = FMT_I;
            OPC_OPIMM:          fmt = (funct3 == F3_SLLI || funct3 == F3_SRXI) ? FMT_SH : FMT_I;
            OPC_STORE:          fmt = FMT_S;
            OPC_BRANCH:         fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            OPC_SYSTEM:         fmt = (funct3 == F3_PRIV) ? FMT_I : FMT_Z;
            default:            illegal = 1'b1;
        endcase
    end

    // Every format is built as a 32-bit value; zero-extended formats keep bit 31 clear,
    // so one sign-extension to XLEN covers all of them.
    always_comb begin
        imm32 = 32'd0;
        case (fmt)
            FMT_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:  imm32 = {instr[31:12], 12'd0};
            FMT_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_SH: imm32 = (XLEN == 64) ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
            FMT_Z:  imm32 = {27'd0, instr[19:15]};
            default: imm32 = 32'd0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extractor feeding the ALU operand mux through a two-entry skid stage.
// Latency: 1 cycle from accept to out_valid; 1 word/cycle while out_ready is high.
// Backpressure: absorbs two words with out_ready low; in_ready is registered and drops when full.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]      state, state_nxt;
    logic            accept, emit;
    logic            load_main, load_skid, pop_skid;
    logic [XLEN-1:0] dec_imm, skid_imm;
    logic [2:0]      dec_fmt, skid_fmt;
    logic            dec_ill, skid_ill;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                load_main = 1'b1;
            end
            ONE: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: if (emit) begin
                state_nxt = ONE;
                pop_skid  = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            imm      <= '0;
            fmt      <= FMT_NONE;
            illegal  <= 1'b0;
            skid_imm <= '0;
            skid_fmt <= FMT_NONE;
            skid_ill <= 1'b0;
        end else begin
            state    <= state_nxt;
            // Looking ahead at the next state keeps in_ready off the out_ready path.
            in_ready <= (state_nxt != FULL);
            if (load_main) begin
                imm     <= dec_imm;
                fmt     <= dec_fmt;
                illegal <= dec_ill;
            end else if (pop_skid) begin
                imm     <= skid_imm;
                fmt     <= skid_fmt;
                illegal <= skid_ill;
            end
            if (load_skid) begin
                skid_imm <= dec_imm;
                skid_fmt <= dec_fmt;
                skid_ill <= dec_ill;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed-vector bench for imm_extend_pipe at XLEN=32 and XLEN=64.
// Latency: n/a.
// Backpressure: exercises skid fill, drain and reset while full.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;

    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [31:0] instr_w;
    logic [63:0] imm_w;
    logic [2:0]  fmt_w;
    logic        illegal_w;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm       (imm),
        .fmt       (fmt),
        .illegal   (illegal)
    );

    imm_extend_pipe #(.XLEN(64)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .instr     (instr_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .imm       (imm_w),
        .fmt       (fmt_w),
        .illegal   (illegal_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input string tag, input logic [31:0] w, input logic [31:0] e_imm,
                          input logic [2:0] e_fmt, input logic e_ill);
        instr     = w;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1);
        step;
        in_valid = 1'b0;
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".imm"}, imm, e_imm);
        chk({tag, ".fmt"}, fmt, e_fmt);
        chk({tag, ".illegal"}, illegal, e_ill);
        step;
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    task automatic send64(input string tag, input logic [31:0] w, input logic [63:0] e_imm,
                          input logic [2:0] e_fmt);
        instr_w    = w;
        in_valid_w = 1'b1;
        step;
        in_valid_w = 1'b0;
        chk({tag, ".out_valid"}, out_valid_w, 1);
        chk({tag, ".imm"}, imm_w, e_imm);
        chk({tag, ".fmt"}, fmt_w, e_fmt);
        step;
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instr       = 32'd0;
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;
        instr_w     = 32'd0;
        step;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.imm", imm, 0);
        chk("rst.fmt", fmt, 0);
        chk("rst.illegal", illegal, 0);
        rst_n = 1'b1;
        step;
        chk("idle.out_valid", out_valid, 0);

        send32("addi",  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        send32("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
        send32("beq",   32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
        send32("jal",   32'h0010006F, 32'h00000800, 3'd5, 1'b0);
        send32("lui",   32'h123452B7, 32'h12345000, 3'd4, 1'b0);
        send32("srai",  32'h4030D093, 32'h00000003, 3'd6, 1'b0);
        send32("csrwi", 32'h3402D073, 32'h00000005, 3'd7, 1'b0);
        send32("ecall", 32'h00000073, 32'h00000000, 3'd1, 1'b0);
        send32("zero",  32'h00000000, 32'h00000000, 3'd0, 1'b1);

        // Back-to-back with the output stalled: two words absorbed, third held upstream.
        out_ready = 1'b0;
        instr     = 32'hFFF00093;
        in_valid  = 1'b1;
        step;
        chk("b2b.1.in_ready", in_ready, 1);
        chk("b2b.1.imm", imm, 32'hFFFFFFFF);
        instr = 32'h123452B7;
        step;
        chk("b2b.2.in_ready", in_ready, 0);
        chk("b2b.2.out_valid", out_valid, 1);
        instr = 32'h0010006F;
        step;
        chk("b2b.3.in_ready", in_ready, 0);
        chk("b2b.3.hold_imm", imm, 32'hFFFFFFFF);
        chk("b2b.3.hold_fmt", fmt, 1);
        out_ready = 1'b1;
        step;
        chk("b2b.e2.imm", imm, 32'h12345000);
        chk("b2b.e2.fmt", fmt, 4);
        chk("b2b.e2.in_ready", in_ready, 1);
        step;
        in_valid = 1'b0;
        chk("b2b.e3.out_valid", out_valid, 1);
        chk("b2b.e3.imm", imm, 32'h00000800);
        chk("b2b.e3.fmt", fmt, 5);
        step;
        chk("b2b.drained", out_valid, 0);

        // Reset while FULL must clear immediately and leave nothing behind.
        out_ready = 1'b0;
        instr     = 32'h4030D093;
        in_valid  = 1'b1;
        step;
        instr = 32'hFE112E23;
        step;
        in_valid = 1'b0;
        chk("full.in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", out_valid, 0);
        chk("mid_rst.in_ready", in_ready, 1);
        chk("mid_rst.imm", imm, 0);
        step;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step;
        chk("post_rst.out_valid.0", out_valid, 0);
        step;
        chk("post_rst.out_valid.1", out_valid, 0);
        chk("post_rst.in_ready", in_ready, 1);

        send64("w.slli", 32'h03F09093, 64'h000000000000003F, 3'd6);
        send64("w.lui",  32'h800002B7, 64'hFFFFFFFF80000000, 3'd4);
        send64("w.addi", 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        chk("w.drained", out_valid_w, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, registered immediate-extraction and extension unit for the RV32I core. It decodes the opcode of a 32-bit instruction word, selects the immediate format (I, S, B, U, J, shift-amount, CSR zimm), and extends the immediate to XLEN bits. The result passes through a valid/ready output stage with a skid register. It sits between the fetch/decode register and the ALU operand mux. It replaces the fixed combinational 12-to-32 extender.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  unit can accept a word; registered.
- instr  in  32  instruction word.
- out_valid  out  1  output immediate valid.
- out_ready  in  1  downstream accepts output.
- imm  out  XLEN  extended immediate.
- fmt  out  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6, Z=7.
- illegal  out  1  opcode has no immediate decode; imm is forced to 0.

## Operation
- The format is decoded from instr[6:0]:
  - 0000011, 1100111: I.
  - 0010011 with funct3 001/101: SH. Otherwise 0010011 is I.
  - 0100011: S.
  - 1100011: B.
  - 0110111, 0010111: U.
  - 1101111: J.
  - 1110011 with funct3 != 000: Z. With funct3 = 000: I.
  - Anything else: NONE, illegal=1.
- Immediate construction for each format:
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25], instr[11:7]}, sign-extended.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, sign-extended.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31. For XLEN=64, bits 63:32 copy instr[31].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}, sign-extended.
  - SH: zero-extended shift amount. instr[24:20] when XLEN=32; instr[25:20] when XLEN=64. funct7 bits are never part of imm.
  - Z: instr[19:15], zero-extended.
- Decode and extension are combinational on instr. The result is registered into the output stage.
- Output stage has two entries: main register and skid register.
  - Accept on in_valid && in_ready.
  - Emit on out_valid && out_ready.
- States: EMPTY, ONE (main full), FULL (main + skid full).
  - EMPTY, accept: → ONE.
  - ONE, accept without emit: → FULL; the word goes to skid.
  - ONE, accept with emit: stays ONE; main reloads with the new word.
  - ONE, emit without accept: → EMPTY.
  - FULL, emit: → ONE; skid moves to main. No accept is possible in FULL.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is driven from a register, not from out_ready.
- Order is strictly preserved. No word is dropped or duplicated.
- illegal travels with its word. It does not stall the stage.

## Timing
- Reset, asynchronous on rst_n low:
  - State → EMPTY.
  - out_valid=0, in_ready=1, imm=0, fmt=0, illegal=0.
  - Skid contents are discarded.
- Latency: a word accepted at edge N appears on imm/fmt/illegal with out_valid=1 after edge N. That is 1 cycle.
- Throughput is 1 word/cycle while out_ready=1.
- With out_ready held 0, two words are absorbed. in_ready falls the cycle after the second accept.
- While out_valid=1 and out_ready=0, imm/fmt/illegal must not change.
- Simultaneous accept and emit in ONE: state does not change. The new data is visible the following cycle.
- Reset asserted mid-operation (ONE or FULL): state clears immediately. No partial word is emitted after release.
- in_valid while in_ready=0 is ignored. The upstream must hold instr stable until accepted.

## Structure
- Shared package imm_pkg, containing:
  - fmt codes as localparams.
  - opcode constants: OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM.
  - funct3 shift codes.
- One combinational sub-module, imm_decode, takes instr and outputs {imm, fmt, illegal} for a given XLEN.
- The top level holds the two-entry skid stage and the state register.

## Test plan
- addi 0xFFF00093 → imm=0xFFFFFFFF, fmt=1, out_valid 1 cycle after accept.
- sw 0xFE112E23 → imm=0xFFFFFFFC, fmt=2.
- jal 0x0010006F → imm=0x00000800, fmt=5.
- lui 0x123452B7 → imm=0x12345000, fmt=4.
- srai 0x4030D093 → imm=0x00000003, fmt=6 (not 0x403).
- Opcode 0x00000000 → imm=0, fmt=0, illegal=1.
- Back-to-back 0xFFF00093, 0x123452B7, 0x0010006F with out_ready=0 for 3 cycles:
  - in_ready drops after the second accept; the third word is held upstream.
  - Releasing out_ready emits the three words in order on consecutive cycles.
- rst_n pulsed low while FULL → out_valid=0 and in_ready=1 immediately; no stale word appears after release.
- XLEN=64, slli 0x03F09093 → imm=0x000000000000003F; lui 0x800002B7 → imm=0xFFFFFFFF80000000.
